// File: rtl/stopwatch_command_receiver.sv
// Stopwatch command receiver: UART (8N1) byte receiver plus a command parser
// that turns 'S', 'P', 'R' and "Tmmss" commands into run/clear/load controls.
module stopwatch_command_receiver #(
  parameter int CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int BAUD_RATE             = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        usb_rx,
  output logic        run,
  output logic        clear,
  output logic        load,
  output logic [15:0] load_digits,
  output logic        rx_error
);

  localparam int CLOCKS_PER_BIT = CLOCK_FREQUENCY_IN_HZ / BAUD_RATE;
  localparam int CW             = $clog2(CLOCKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rxState_t;

  typedef enum logic [2:0] {
    PS_CMD,
    PS_DIG_M10,
    PS_DIG_M1,
    PS_DIG_S10,
    PS_DIG_S1
  } psState_t;

  // Synchronizer and a two-deep "pin sampled" marker: the synchronizer's
  // reset ones are not a real line level, so arming waits until a level
  // that actually came from the pin has reached the synchronizer output.
  logic [1:0] sync_q;
  logic [1:0] pinSeen_q;
  logic       rxLine;
  logic       lineTrusted;

  // Receiver state
  rxState_t      rxState_q, rxState_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          armed_q, armed_d;
  logic          byteValid_q, byteValid_d;
  logic          frameErr_q, frameErr_d;

  // Parser state
  psState_t    psState_q, psState_d;
  logic        run_q, run_d;
  logic        clear_q, clear_d;
  logic        load_q, load_d;
  logic        rxError_q, rxError_d;
  logic [15:0] loadDigits_q, loadDigits_d;
  logic [11:0] stage_q, stage_d;
  logic [7:0]  digitLimit;
  logic        digitOk;

  assign rxLine      = sync_q[1];
  assign lineTrusted = pinSeen_q[1];

  // Bring the asynchronous UART line into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 2'b11;
      pinSeen_q <= 2'b00;
    end else begin
      sync_q    <= {sync_q[0], usb_rx};
      pinSeen_q <= {pinSeen_q[0], 1'b1};
    end
  end

  // Receiver registers: frame FSM, bit timing, shift register and strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxState_q   <= RX_IDLE;
      cnt_q       <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      rxState_q   <= rxState_d;
      cnt_q       <= cnt_d;
      bitIdx_q    <= bitIdx_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      byteValid_q <= byteValid_d;
      frameErr_q  <= frameErr_d;
    end
  end

  // Receiver next state: find a start edge, confirm it mid-bit, sample eight
  // data bits at bit centres, then judge the stop bit.  A low stop bit
  // disarms the receiver so a held-low line cannot start a bogus frame.
  always_comb begin
    rxState_d   = rxState_q;
    cnt_d       = cnt_q;
    bitIdx_d    = bitIdx_q;
    shift_d     = shift_q;
    armed_d     = armed_q | (lineTrusted & rxLine);
    byteValid_d = 1'b0;
    frameErr_d  = 1'b0;
    unique case (rxState_q)
      RX_IDLE: begin
        if (armed_q && !rxLine) begin
          rxState_d = RX_START;
          cnt_d     = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rxLine) begin
            rxState_d = RX_DATA;
            bitIdx_d  = '0;
          end else begin
            rxState_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxLine, shift_q[7:1]};
          if (bitIdx_q == 3'd7) begin
            rxState_d = RX_STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          rxState_d = RX_IDLE;
          if (rxLine) begin
            byteValid_d = 1'b1;
          end else begin
            frameErr_d = 1'b1;
            armed_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: rxState_d = RX_IDLE;
    endcase
  end

  // Tens digits only go up to 5; ASCII digits carry their value in the low nibble.
  assign digitLimit = (psState_q == PS_DIG_M10 || psState_q == PS_DIG_S10) ? 8'h35 : 8'h39;
  assign digitOk    = (shift_q >= 8'h30) && (shift_q <= digitLimit);

  // Parser registers and the registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      psState_q    <= PS_CMD;
      run_q        <= 1'b0;
      clear_q      <= 1'b0;
      load_q       <= 1'b0;
      rxError_q    <= 1'b0;
      loadDigits_q <= 16'h0000;
      stage_q      <= '0;
    end else begin
      psState_q    <= psState_d;
      run_q        <= run_d;
      clear_q      <= clear_d;
      load_q       <= load_d;
      rxError_q    <= rxError_d;
      loadDigits_q <= loadDigits_d;
      stage_q      <= stage_d;
    end
  end

  // Parser next state: decode commands, collect four time digits in a
  // staging register and only commit them to load_digits on the last one.
  always_comb begin
    psState_d    = psState_q;
    run_d        = run_q;
    clear_d      = 1'b0;
    load_d       = 1'b0;
    rxError_d    = 1'b0;
    loadDigits_d = loadDigits_q;
    stage_d      = stage_q;
    if (frameErr_q) begin
      rxError_d = 1'b1;
      psState_d = PS_CMD;
    end else if (byteValid_q) begin
      if (psState_q == PS_CMD) begin
        unique case (shift_q)
          8'h53: run_d = 1'b1;
          8'h50: run_d = 1'b0;
          8'h52: begin
            run_d   = 1'b0;
            clear_d = 1'b1;
          end
          8'h54: psState_d = PS_DIG_M10;
          default: ;
        endcase
      end else if (!digitOk) begin
        rxError_d = 1'b1;
        psState_d = PS_CMD;
      end else begin
        unique case (psState_q)
          PS_DIG_M10: begin
            stage_d[11:8] = shift_q[3:0];
            psState_d     = PS_DIG_M1;
          end
          PS_DIG_M1: begin
            stage_d[7:4] = shift_q[3:0];
            psState_d    = PS_DIG_S10;
          end
          PS_DIG_S10: begin
            stage_d[3:0] = shift_q[3:0];
            psState_d    = PS_DIG_S1;
          end
          PS_DIG_S1: begin
            loadDigits_d = {stage_q, shift_q[3:0]};
            load_d       = 1'b1;
            psState_d    = PS_CMD;
          end
          default: psState_d = PS_CMD;
        endcase
      end
    end
  end

  assign run         = run_q;
  assign clear       = clear_q;
  assign load        = load_q;
  assign rx_error    = rxError_q;
  assign load_digits = loadDigits_q;

endmodule

// File: tb/tb_stopwatch_command_receiver.sv
// Testbench for stopwatch_command_receiver: UART frames are driven onto the
// line and the observed output events are compared with a command-level model.
module tb_stopwatch_command_receiver;

  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int CPB    = CLK_HZ / BAUD;

  localparam int EV_RISE  = 1;
  localparam int EV_FALL  = 2;
  localparam int EV_CLEAR = 3;
  localparam int EV_LOAD  = 4;
  localparam int EV_ERR   = 5;

  logic        clk;
  logic        rst;
  logic        usbRx;
  logic        run;
  logic        clear;
  logic        load;
  logic [15:0] loadDigits;
  logic        rxError;

  int checks = 0;
  int errors = 0;
  int obsQ[$];
  int expQ[$];

  // Command-level model state
  logic        mRun;
  int          mState;
  logic [3:0]  mDig[4];
  logic [15:0] mLoaded;
  logic        prevRun;

  stopwatch_command_receiver #(
    .CLOCK_FREQUENCY_IN_HZ(CLK_HZ),
    .BAUD_RATE(BAUD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .usb_rx(usbRx),
    .run(run),
    .clear(clear),
    .load(load),
    .load_digits(loadDigits),
    .rx_error(rxError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ev(input int kind, input logic [15:0] d);
    return kind * 65536 + int'(d);
  endfunction

  function automatic int evAt(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int firstDiff();
    int n;
    n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < n; i++) if (obsQ[i] != expQ[i]) return i;
    if (obsQ.size() != expQ.size()) return n;
    return -1;
  endfunction

  function automatic void modelReset();
    mRun    = 1'b0;
    mState  = 0;
    mLoaded = 16'h0000;
    for (int i = 0; i < 4; i++) mDig[i] = 4'h0;
  endfunction

  function automatic void modelFrameError();
    expQ.push_back(ev(EV_ERR, 16'h0));
    mState = 0;
  endfunction

  // The model reads the byte stream as text: a command letter, or one of the
  // four time digits with its own allowed range.
  function automatic void modelByte(input logic [7:0] b);
    logic [7:0] lim;
    logic [7:0] val;
    if (mState == 0) begin
      if (b == "S") begin
        if (!mRun) expQ.push_back(ev(EV_RISE, 16'h0));
        mRun = 1'b1;
      end else if (b == "P") begin
        if (mRun) expQ.push_back(ev(EV_FALL, 16'h0));
        mRun = 1'b0;
      end else if (b == "R") begin
        if (mRun) expQ.push_back(ev(EV_FALL, 16'h0));
        expQ.push_back(ev(EV_CLEAR, 16'h0));
        mRun = 1'b0;
      end else if (b == "T") begin
        mState = 1;
      end
    end else begin
      lim = (mState == 1 || mState == 3) ? "5" : "9";
      if (b >= "0" && b <= lim) begin
        val = b - 8'h30;
        mDig[mState-1] = val[3:0];
        if (mState == 4) begin
          mLoaded = {mDig[0], mDig[1], mDig[2], mDig[3]};
          expQ.push_back(ev(EV_LOAD, mLoaded));
          mState = 0;
        end else begin
          mState = mState + 1;
        end
      end else begin
        expQ.push_back(ev(EV_ERR, 16'h0));
        mState = 0;
      end
    end
  endfunction

  // Output monitor: logs run edges and pulses in a fixed per-cycle order
  // and checks that the three pulse outputs never coincide.
  always @(negedge clk) begin
    if (rst) begin
      prevRun = run;
    end else begin
      if (run && !prevRun) obsQ.push_back(ev(EV_RISE, 16'h0));
      if (!run && prevRun) obsQ.push_back(ev(EV_FALL, 16'h0));
      if (clear) obsQ.push_back(ev(EV_CLEAR, 16'h0));
      if (load) obsQ.push_back(ev(EV_LOAD, loadDigits));
      if (rxError) obsQ.push_back(ev(EV_ERR, 16'h0));
      if (clear || load || rxError) begin
        checks++;
        if ($countones({clear, load, rxError}) > 1) begin
          errors++;
          $display("[TB] FAIL pulse_exclusive: observed clear=%b load=%b rx_error=%b, required at most one", clear, load, rxError);
        end
      end
      prevRun = run;
    end
  end

  task automatic driveBit(input logic v);
    usbRx = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Drive one 8N1 frame; a bad stop bit is held low past its sample point.
  task automatic applyStimulus(input logic [7:0] b, input logic goodStop);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
    if (goodStop) begin
      driveBit(1'b1);
      modelByte(b);
    end else begin
      usbRx = 1'b0;
      repeat (CPB / 2 + 10) @(negedge clk);
      usbRx = 1'b1;
      repeat (CPB) @(negedge clk);
      modelFrameError();
    end
  endtask

  task automatic sendString(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      applyStimulus(s[i], 1'b1);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic startScenario();
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    usbRx = 1'b1;
    modelReset();
    repeat (4) @(negedge clk);
    checks++;
    if (run !== 1'b0) begin errors++; $display("[TB] FAIL reset_run: observed %b required 0", run); end
    checks++;
    if (clear !== 1'b0) begin errors++; $display("[TB] FAIL reset_clear: observed %b required 0", clear); end
    checks++;
    if (load !== 1'b0) begin errors++; $display("[TB] FAIL reset_load: observed %b required 0", load); end
    checks++;
    if (rxError !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_error: observed %b required 0", rxError); end
    checks++;
    if (loadDigits !== 16'h0000) begin errors++; $display("[TB] FAIL reset_load_digits: observed %h required 0000", loadDigits); end
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    checks++;
    if (obsQ.size() != 0) begin errors++; $display("[TB] FAIL reset_idle_events: observed %0d events required 0", obsQ.size()); end
  endtask

  task automatic test_start_stop();
    int d;
    startScenario();
    applyStimulus("S", 1'b1);
    checks++;
    if (run !== 1'b1) begin errors++; $display("[TB] FAIL start_run: observed %b required 1", run); end
    repeat (20) @(negedge clk);
    applyStimulus("P", 1'b1);
    checks++;
    if (run !== 1'b0) begin errors++; $display("[TB] FAIL stop_run: observed %b required 0", run); end
    repeat (3 * CPB) @(negedge clk);
    d = firstDiff();
    checks++;
    if (d >= 0) begin errors++; $display("[TB] FAIL start_stop_events: at %0d observed 0x%0h required 0x%0h", d, evAt(obsQ, d), evAt(expQ, d)); end
  endtask

  task automatic test_load();
    int d;
    startScenario();
    sendString("T5907", 15);
    repeat (3 * CPB) @(negedge clk);
    d = firstDiff();
    checks++;
    if (d >= 0) begin errors++; $display("[TB] FAIL load_events: at %0d observed 0x%0h required 0x%0h", d, evAt(obsQ, d), evAt(expQ, d)); end
    checks++;
    if (loadDigits !== mLoaded) begin errors++; $display("[TB] FAIL load_digits: observed %h required %h", loadDigits, mLoaded); end
  endtask

  task automatic test_invalid_digit();
    int d;
    startScenario();
    sendString("T6", 7);
    repeat (3 * CPB) @(negedge clk);
    checks++;
    if (loadDigits !== mLoaded) begin errors++; $display("[TB] FAIL invalid_holds_digits: observed %h required %h", loadDigits, mLoaded); end
    sendString("T0001", 3);
    repeat (3 * CPB) @(negedge clk);
    d = firstDiff();
    checks++;
    if (d >= 0) begin errors++; $display("[TB] FAIL invalid_events: at %0d observed 0x%0h required 0x%0h", d, evAt(obsQ, d), evAt(expQ, d)); end
    checks++;
    if (loadDigits !== mLoaded) begin errors++; $display("[TB] FAIL invalid_then_load: observed %h required %h", loadDigits, mLoaded); end
  endtask

  task automatic test_framing_and_glitch();
    int d;
    startScenario();
    applyStimulus("S", 1'b0);
    repeat (3 * CPB) @(negedge clk);
    checks++;
    if (run !== mRun) begin errors++; $display("[TB] FAIL framing_run: observed %b required %b", run, mRun); end
    usbRx = 1'b0;
    repeat (30) @(negedge clk);
    usbRx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    d = firstDiff();
    checks++;
    if (d >= 0) begin errors++; $display("[TB] FAIL framing_glitch_events: at %0d observed 0x%0h required 0x%0h", d, evAt(obsQ, d), evAt(expQ, d)); end
  endtask

  task automatic test_clear();
    int d;
    startScenario();
    sendString("SR", 25);
    repeat (3 * CPB) @(negedge clk);
    d = firstDiff();
    checks++;
    if (d >= 0) begin errors++; $display("[TB] FAIL clear_events: at %0d observed 0x%0h required 0x%0h", d, evAt(obsQ, d), evAt(expQ, d)); end
    checks++;
    if (run !== 1'b0) begin errors++; $display("[TB] FAIL clear_run: observed %b required 0", run); end
  endtask

  task automatic test_reset_midframe();
    int d;
    sendString("S", 10);
    sendString("T", 10);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    usbRx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (run !== 1'b0) begin errors++; $display("[TB] FAIL midreset_run: observed %b required 0", run); end
    checks++;
    if (loadDigits !== 16'h0000) begin errors++; $display("[TB] FAIL midreset_load_digits: observed %h required 0000", loadDigits); end
    checks++;
    if ({clear, load, rxError} !== 3'b000) begin errors++; $display("[TB] FAIL midreset_pulses: observed %b required 000", {clear, load, rxError}); end
    modelReset();
    startScenario();
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    usbRx = 1'b1;
    repeat (CPB) @(negedge clk);
    sendString("T1234", 5);
    repeat (3 * CPB) @(negedge clk);
    d = firstDiff();
    checks++;
    if (d >= 0) begin errors++; $display("[TB] FAIL midreset_events: at %0d observed 0x%0h required 0x%0h", d, evAt(obsQ, d), evAt(expQ, d)); end
    checks++;
    if (loadDigits !== 16'h1234) begin errors++; $display("[TB] FAIL midreset_reload: observed %h required 1234", loadDigits); end
  endtask

  task automatic test_back_to_back();
    int d;
    startScenario();
    sendString("ST1234P", 0);
    repeat (3 * CPB) @(negedge clk);
    d = firstDiff();
    checks++;
    if (d >= 0) begin errors++; $display("[TB] FAIL back_to_back_events: at %0d observed 0x%0h required 0x%0h", d, evAt(obsQ, d), evAt(expQ, d)); end
    checks++;
    if (run !== 1'b0) begin errors++; $display("[TB] FAIL back_to_back_run: observed %b required 0", run); end
  endtask

  task automatic test_random();
    int d;
    int kind;
    logic [7:0] b;
    startScenario();
    for (int i = 0; i < 16; i++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0: b = "S";
        1: b = "P";
        2: b = "R";
        3, 4: b = "T";
        5, 6, 7: b = 8'(8'h30 + $urandom_range(0, 9));
        default: b = 8'($urandom_range(0, 255));
      endcase
      applyStimulus(b, kind != 9);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    repeat (3 * CPB) @(negedge clk);
    d = firstDiff();
    checks++;
    if (d >= 0) begin errors++; $display("[TB] FAIL random_events: at %0d observed 0x%0h required 0x%0h", d, evAt(obsQ, d), evAt(expQ, d)); end
    checks++;
    if (run !== mRun) begin errors++; $display("[TB] FAIL random_run: observed %b required %b", run, mRun); end
    checks++;
    if (loadDigits !== mLoaded) begin errors++; $display("[TB] FAIL random_load_digits: observed %h required %h", loadDigits, mLoaded); end
  endtask

  // Scenario sequence
  initial begin
    rst   = 1'b1;
    usbRx = 1'b1;
    test_reset();
    test_start_stop();
    test_load();
    test_invalid_digit();
    test_framing_and_glitch();
    test_clear();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
